clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl.sv | 115 +++++++++++
 tb/tb_clk_gate_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller for a downstream AND-type clock gate.
// The FSM (RUN -> DRAIN -> GATED -> WAKE -> RUN) decides when the gated
// domain has been quiet long enough to stop its clock. It also sequences
// the wake-up. The enable leaving the block is re-timed on the falling
// edge, so it only changes while clk is low and the AND gate cannot glitch.
`timescale 1ns/1ps

module clk_gate_ctrl #(
  parameter int IDLE_CNT = 8,  // consecutive idle cycles before gating (1..255)
  parameter int WAKE_CNT = 2   // cycles from enable reassertion to wake_ack (1..15)
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        busy_in,
  input  logic        wake_req,
  input  logic        force_on,
  output logic        en,
  output logic        gated,
  output logic        wake_ack,
  output logic [15:0] gated_cycles
);

  typedef enum logic [1:0] {RUN, DRAIN, GATED, WAKE} state_t;

  localparam logic [8:0] IDLE_LIM = 9'(IDLE_CNT);
  localparam logic [4:0] WAKE_LIM = 5'(WAKE_CNT);

  state_t     state;
  logic [7:0] idle_cnt;
  logic [3:0] wake_cnt;
  logic       en_int;

  logic       idle;
  logic [8:0] idle_inc;
  logic [4:0] wake_inc;

  // The counter stays at 0 in RUN, so the same increment serves both RUN and
  // DRAIN. An IDLE_CNT of 1 then gates straight from RUN.
  assign idle     = !busy_in && !wake_req && !force_on;
  assign idle_inc = {1'b0, idle_cnt} + 9'd1;
  assign wake_inc = {1'b0, wake_cnt} + 5'd1;

  // Main FSM with registered enable, gated flag and wake acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      idle_cnt <= 8'd0;
      wake_cnt <= 4'd0;
      en_int   <= 1'b1;
      gated    <= 1'b0;
      wake_ack <= 1'b0;
    end else begin
      wake_ack <= 1'b0;
      case (state)
        RUN, DRAIN: begin
          // Non-idle input wins over a terminal count, so no gating happens then.
          if (!idle) begin
            state    <= RUN;
            idle_cnt <= 8'd0;
            // A request seen while ack is already high is the one being acked.
            // Only a request still present one cycle later counts as new.
            if (wake_req && !wake_ack)
              wake_ack <= 1'b1;
          end else if (idle_inc >= IDLE_LIM) begin
            state    <= GATED;
            idle_cnt <= 8'd0;
            en_int   <= 1'b0;
            gated    <= 1'b1;
          end else begin
            state    <= DRAIN;
            idle_cnt <= idle_inc[7:0];
          end
        end
        GATED: begin
          if (!idle) begin
            state    <= WAKE;
            en_int   <= 1'b1;
            gated    <= 1'b0;
            wake_cnt <= 4'd0;
          end
        end
        WAKE: begin
          // Inputs are ignored here. The clock is being restored, so no re-gating.
          if (wake_inc >= WAKE_LIM) begin
            state    <= RUN;
            wake_cnt <= 4'd0;
            wake_ack <= 1'b1;
          end else begin
            wake_cnt <= wake_inc[3:0];
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Saturating count of cycles spent gated; only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      gated_cycles <= 16'd0;
    else if (state == GATED && gated_cycles != 16'hFFFF)
      gated_cycles <= gated_cycles + 16'd1;
  end

  // Falling-edge re-time of the enable so the AND-gated clock never glitches
  always_ff @(negedge clk or negedge rst) begin
    if (!rst)
      en <= 1'b1;
    else
      en <= en_int;
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed testbench for clk_gate_ctrl with IDLE_CNT=4 and WAKE_CNT=2.
`timescale 1ns/1ps

module tb_clk_gate_ctrl;

  logic        clk;
  logic        rst;
  logic        busy_in;
  logic        wake_req;
  logic        force_on;
  logic        en;
  logic        gated;
  logic        wake_ack;
  logic [15:0] gated_cycles;

  int n_checks;
  int n_errors;

  clk_gate_ctrl #(.IDLE_CNT(4), .WAKE_CNT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .busy_in      (busy_in),
    .wake_req     (wake_req),
    .force_on     (force_on),
    .en           (en),
    .gated        (gated),
    .wake_ack     (wake_ack),
    .gated_cycles (gated_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to 1 ns after the next falling edge
  task automatic half();
    @(negedge clk);
    #1;
  endtask

  // Reset with idle inputs; returns just after a falling edge, so the next
  // rising edge is the first one after reset.
  task automatic do_reset();
    busy_in  = 1'b0;
    wake_req = 1'b0;
    force_on = 1'b0;
    half();
    rst = 1'b0;
    half();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL reset_en got %b want 1", en); end
    n_checks++; if (gated !== 1'b0) begin n_errors++; $display("FAIL reset_gated got %b want 0", gated); end
    n_checks++; if (wake_ack !== 1'b0) begin n_errors++; $display("FAIL reset_ack got %b want 0", wake_ack); end
    n_checks++; if (gated_cycles !== 16'd0) begin n_errors++; $display("FAIL reset_gc got %0d want 0", gated_cycles); end
  endtask

  task automatic test_idle_gate();
    do_reset();
    repeat (3) step();
    n_checks++; if (gated !== 1'b0) begin n_errors++; $display("FAIL idle3_gated got %b want 0", gated); end
    half();
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL idle3_en got %b want 1", en); end
    step();
    n_checks++; if (gated !== 1'b1) begin n_errors++; $display("FAIL idle4_gated got %b want 1", gated); end
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL idle4_en_before_neg got %b want 1", en); end
    half();
    n_checks++; if (en !== 1'b0) begin n_errors++; $display("FAIL idle4_en_after_neg got %b want 0", en); end
    n_checks++; if (gated_cycles !== 16'd0) begin n_errors++; $display("FAIL gc0 got %0d want 0", gated_cycles); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++; if (gated_cycles !== 16'(i)) begin n_errors++; $display("FAIL gc_count got %0d want %0d", gated_cycles, i); end
    end
  endtask

  task automatic test_drain_abort();
    do_reset();
    repeat (3) step();
    busy_in = 1'b1;
    step();
    busy_in = 1'b0;
    n_checks++; if (gated !== 1'b0) begin n_errors++; $display("FAIL abort_gated got %b want 0", gated); end
    half();
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL abort_en got %b want 1", en); end
    repeat (3) step();
    n_checks++; if (gated !== 1'b0) begin n_errors++; $display("FAIL abort_3new_gated got %b want 0", gated); end
    step();
    n_checks++; if (gated !== 1'b1) begin n_errors++; $display("FAIL abort_4new_gated got %b want 1", gated); end
  endtask

  task automatic test_wake_from_gated();
    do_reset();
    repeat (4) step();
    step();
    wake_req = 1'b1;
    step();
    n_checks++; if (gated !== 1'b0) begin n_errors++; $display("FAIL wake_entry_gated got %b want 0", gated); end
    n_checks++; if (en !== 1'b0) begin n_errors++; $display("FAIL wake_entry_en got %b want 0", en); end
    n_checks++; if (wake_ack !== 1'b0) begin n_errors++; $display("FAIL wake_entry_ack got %b want 0", wake_ack); end
    half();
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL wake_en_rise got %b want 1", en); end
    step();
    n_checks++; if (wake_ack !== 1'b0) begin n_errors++; $display("FAIL wake_w1_ack got %b want 0", wake_ack); end
    step();
    n_checks++; if (wake_ack !== 1'b1) begin n_errors++; $display("FAIL wake_w2_ack got %b want 1", wake_ack); end
    n_checks++; if (gated_cycles !== 16'd2) begin n_errors++; $display("FAIL wake_gc got %0d want 2", gated_cycles); end
    wake_req = 1'b0;
    step();
    n_checks++; if (wake_ack !== 1'b0) begin n_errors++; $display("FAIL wake_post_ack got %b want 0", wake_ack); end
    half();
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL wake_post_en got %b want 1", en); end
  endtask

  task automatic test_run_wake();
    do_reset();
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    n_checks++; if (wake_ack !== 1'b1) begin n_errors++; $display("FAIL run_ack got %b want 1", wake_ack); end
    half();
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL run_en got %b want 1", en); end
    step();
    n_checks++; if (wake_ack !== 1'b0) begin n_errors++; $display("FAIL run_ack_drop got %b want 0", wake_ack); end
    // wake request in DRAIN: ack, counter cleared, full 4 idle cycles needed again
    step();
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    n_checks++; if (wake_ack !== 1'b1) begin n_errors++; $display("FAIL drain_ack got %b want 1", wake_ack); end
    repeat (3) step();
    n_checks++; if (gated !== 1'b0) begin n_errors++; $display("FAIL drain_req_3_gated got %b want 0", gated); end
    step();
    n_checks++; if (gated !== 1'b1) begin n_errors++; $display("FAIL drain_req_4_gated got %b want 1", gated); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wake_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (wake_ack !== ((i % 2) == 0)) begin n_errors++; $display("FAIL held_req_ack%0d got %b want %b", i, wake_ack, ((i % 2) == 0)); end
    end
    wake_req = 1'b0;
    step();
    n_checks++; if (wake_ack !== 1'b0) begin n_errors++; $display("FAIL held_req_release got %b want 0", wake_ack); end
  endtask

  task automatic test_force_on();
    int bad;
    do_reset();
    repeat (4) step();
    force_on = 1'b1;
    step();
    n_checks++; if (gated !== 1'b0) begin n_errors++; $display("FAIL force_wake_gated got %b want 0", gated); end
    step();
    step();
    n_checks++; if (wake_ack !== 1'b1) begin n_errors++; $display("FAIL force_wake_ack got %b want 1", wake_ack); end
    bad = 0;
    repeat (100) begin
      step();
      if (en !== 1'b1 || gated !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL force_hold got %0d gated/en-low samples want 0", bad); end
    n_checks++; if (gated_cycles !== 16'd1) begin n_errors++; $display("FAIL force_gc got %0d want 1", gated_cycles); end
    force_on = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (4) step();
    repeat (65534) step();
    n_checks++; if (gated_cycles !== 16'hFFFE) begin n_errors++; $display("FAIL sat_pre got %h want fffe", gated_cycles); end
    step();
    n_checks++; if (gated_cycles !== 16'hFFFF) begin n_errors++; $display("FAIL sat_max got %h want ffff", gated_cycles); end
    repeat (3) step();
    n_checks++; if (gated_cycles !== 16'hFFFF) begin n_errors++; $display("FAIL sat_hold got %h want ffff", gated_cycles); end
    n_checks++; if (gated !== 1'b1) begin n_errors++; $display("FAIL sat_gated got %b want 1", gated); end
  endtask

  task automatic test_async_reset();
    int acks;
    // reset while gated, clk high, no edge in between
    do_reset();
    repeat (6) step();
    n_checks++; if (en !== 1'b0) begin n_errors++; $display("FAIL ar_pre_en got %b want 0", en); end
    rst = 1'b0;
    #1;
    n_checks++; if (clk !== 1'b1) begin n_errors++; $display("FAIL ar_clk_phase got %b want 1", clk); end
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL ar_en got %b want 1", en); end
    n_checks++; if (gated !== 1'b0) begin n_errors++; $display("FAIL ar_gated got %b want 0", gated); end
    n_checks++; if (gated_cycles !== 16'd0) begin n_errors++; $display("FAIL ar_gc got %0d want 0", gated_cycles); end
    #1;
    rst = 1'b1;
    acks = 0;
    repeat (4) begin
      step();
      if (wake_ack !== 1'b0) acks++;
    end
    n_checks++; if (acks !== 0) begin n_errors++; $display("FAIL ar_no_ack got %0d acks want 0", acks); end
    // reset while waking: the in-flight wake is abandoned without an ack
    do_reset();
    repeat (4) step();
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL arw_en got %b want 1", en); end
    n_checks++; if (wake_ack !== 1'b0) begin n_errors++; $display("FAIL arw_ack got %b want 0", wake_ack); end
    #1;
    rst = 1'b1;
    acks = 0;
    repeat (4) begin
      step();
      if (wake_ack !== 1'b0) acks++;
    end
    n_checks++; if (acks !== 0) begin n_errors++; $display("FAIL arw_no_ack got %0d acks want 0", acks); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    busy_in  = 1'b0;
    wake_req = 1'b0;
    force_on = 1'b0;
    rst      = 1'b1;
    #1;
    rst = 1'b0;
    test_reset();
    test_idle_gate();
    test_drain_abort();
    test_wake_from_gated();
    test_run_wake();
    test_back_to_back();
    test_force_on();
    test_async_reset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
